// File: rtl/roi_capture.sv
// Captures a fixed region of interest from the raster pixel stream into a
// ping-pong buffer. Optional drop counter: define ROI_DROP_COUNT_EN.
module roi_capture #(
    parameter int X_RES_MAX = 600,
    parameter int Y_RES_MAX = 800,
    parameter int X_W       = 10,
    parameter int Y_W       = 10,
    parameter int PIXEL_W   = 9,
    parameter int ROI_X0    = 0,
    parameter int ROI_Y0    = 0,
    parameter int ROI_W     = 28,
    parameter int ROI_H     = 28,
    parameter int ADDR_W    = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [X_W-1:0]     screen_x_pos,
    input  logic [Y_W-1:0]     screen_y_pos,
    input  logic [PIXEL_W-1:0] pixel,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [PIXEL_W-1:0] rd_data,
    output logic               frame_rdy,
    input  logic               frame_ack,
    output logic               capture_busy
`ifdef ROI_DROP_COUNT_EN
   ,output logic [7:0]         dropped_frames
`endif
);

    localparam int DEPTH = ROI_W * ROI_H;

    // ROI bounds clipped to the visible screen; the raster never exceeds *_RES_MAX.
    localparam int X_END  = (ROI_X0 + ROI_W > X_RES_MAX + 1) ? X_RES_MAX + 1 : ROI_X0 + ROI_W;
    localparam int Y_END  = (ROI_Y0 + ROI_H > Y_RES_MAX + 1) ? Y_RES_MAX + 1 : ROI_Y0 + ROI_H;
    localparam int X_SPAN = (X_END > ROI_X0) ? X_END - ROI_X0 : 0;
    localparam int Y_SPAN = (Y_END > ROI_Y0) ? Y_END - ROI_Y0 : 0;

    localparam logic [X_W:0]      X_LO   = (X_W+1)'(ROI_X0);
    localparam logic [Y_W:0]      Y_LO   = (Y_W+1)'(ROI_Y0);
    localparam logic [X_W:0]      X_LEN  = (X_W+1)'(X_SPAN);
    localparam logic [Y_W:0]      Y_LEN  = (Y_W+1)'(Y_SPAN);
    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CAPTURE = 2'd1;
    localparam logic [1:0] ST_COMMIT  = 2'd2;

    logic [1:0]           state, state_nxt;
    logic [ADDR_W-1:0]    wr_cnt, wr_cnt_nxt, base_cnt;
    logic [Y_W+X_W-1:0]   cur_pos, prev_pos;
    logic [X_W:0]         x_off;
    logic [Y_W:0]         y_off;
    logic                 sample, at_origin, in_roi;
    logic                 capture_sample, wr_en, commit_ok;
    logic                 wr_bank, rd_bank;

    logic [PIXEL_W-1:0]   bank_mem [0:1][0:(2**ADDR_W)-1];

    // Offsets wrap to large values left/above the ROI, so one unsigned compare per axis.
    always_comb begin
        cur_pos   = {screen_y_pos, screen_x_pos};
        sample    = (cur_pos != prev_pos);
        at_origin = (cur_pos == '0);
        x_off     = {1'b0, screen_x_pos} - X_LO;
        y_off     = {1'b0, screen_y_pos} - Y_LO;
        in_roi    = (x_off < X_LEN) && (y_off < Y_LEN);
        base_cnt  = at_origin ? '0 : wr_cnt;
    end

    always_comb begin
        state_nxt      = state;
        wr_cnt_nxt     = wr_cnt;
        capture_sample = 1'b0;
        wr_en          = 1'b0;
        case (state)
            ST_IDLE: begin
                if (sample && at_origin) begin
                    state_nxt      = ST_CAPTURE;
                    capture_sample = 1'b1;
                end
            end
            ST_CAPTURE: begin
                capture_sample = sample;
            end
            default: begin
                state_nxt  = ST_IDLE;
                wr_cnt_nxt = '0;
            end
        endcase
        // A sample at the origin restarts the frame, discarding any partial capture.
        if (capture_sample) begin
            wr_cnt_nxt = base_cnt;
            if (in_roi) begin
                wr_en      = 1'b1;
                wr_cnt_nxt = base_cnt + ADDR_W'(1);
                if (base_cnt == LAST) begin
                    state_nxt = ST_COMMIT;
                end
            end
        end
    end

    // Release-then-swap: an ack in the COMMIT cycle lets the new frame through.
    assign commit_ok    = (state == ST_COMMIT) && (!frame_rdy || frame_ack);
    assign rd_bank      = ~wr_bank;
    assign capture_busy = (state == ST_CAPTURE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            wr_cnt    <= '0;
            prev_pos  <= '1;
            wr_bank   <= 1'b0;
            frame_rdy <= 1'b0;
        end else begin
            state    <= state_nxt;
            wr_cnt   <= wr_cnt_nxt;
            prev_pos <= cur_pos;
            if (commit_ok) begin
                wr_bank   <= ~wr_bank;
                frame_rdy <= 1'b1;
            end else if (frame_ack) begin
                frame_rdy <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            bank_mem[wr_bank][base_cnt] <= pixel;
        end
    end

    // Addresses past the ROI land in unused storage: data unspecified, no side effects.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= bank_mem[rd_bank][rd_addr];
        end
    end

`ifdef ROI_DROP_COUNT_EN
    logic commit_drop;
    assign commit_drop = (state == ST_COMMIT) && frame_rdy && !frame_ack;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dropped_frames <= '0;
        end else if (commit_drop && (dropped_frames != 8'hFF)) begin
            dropped_frames <= dropped_frames + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_roi_capture.sv
// Directed bench for roi_capture on a 10x6 raster with a 4x3 ROI at (2,1),
// plus a screen-clipped instance (ROI at x=8) that can never complete.
module tb_roi_capture;

    logic       clock;
    logic       reset;
    logic [9:0] screen_x_pos;
    logic [9:0] screen_y_pos;
    logic [8:0] pixel;
    logic [3:0] rd_addr;
    logic [8:0] rd_data, c_rd_data;
    logic       frame_rdy, c_frame_rdy;
    logic       frame_ack;
    logic       capture_busy, c_capture_busy;
`ifdef ROI_DROP_COUNT_EN
    logic [7:0] dropped_frames, c_dropped_frames;
`endif

    int total = 0;
    int bad   = 0;
    int x, y, ofs;

    roi_capture #(
        .X_RES_MAX(9), .Y_RES_MAX(5), .X_W(10), .Y_W(10), .PIXEL_W(9),
        .ROI_X0(2), .ROI_Y0(1), .ROI_W(4), .ROI_H(3), .ADDR_W(4)
    ) u_dut (
        .clock(clock), .reset(reset),
        .screen_x_pos(screen_x_pos), .screen_y_pos(screen_y_pos), .pixel(pixel),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .frame_rdy(frame_rdy), .frame_ack(frame_ack), .capture_busy(capture_busy)
`ifdef ROI_DROP_COUNT_EN
       ,.dropped_frames(dropped_frames)
`endif
    );

    roi_capture #(
        .X_RES_MAX(9), .Y_RES_MAX(5), .X_W(10), .Y_W(10), .PIXEL_W(9),
        .ROI_X0(8), .ROI_Y0(1), .ROI_W(4), .ROI_H(3), .ADDR_W(4)
    ) u_clip (
        .clock(clock), .reset(reset),
        .screen_x_pos(screen_x_pos), .screen_y_pos(screen_y_pos), .pixel(pixel),
        .rd_addr(rd_addr), .rd_data(c_rd_data),
        .frame_rdy(c_frame_rdy), .frame_ack(frame_ack), .capture_busy(c_capture_busy)
`ifdef ROI_DROP_COUNT_EN
       ,.dropped_frames(c_dropped_frames)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive();
        screen_x_pos = 10'(x);
        screen_y_pos = 10'(y);
        pixel        = 9'(x + ofs);
    endtask

    task automatic advance();
        if (x == 9) begin
            x = 0;
            y = (y == 5) ? 0 : y + 1;
        end else begin
            x = x + 1;
        end
        drive();
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic step();
        advance();
        cyc();
    endtask

    // Advance the raster, holding each position for 'hold' clocks, until (tx,ty) has been presented.
    task automatic run_to(input int tx, input int ty, input int hold);
        int n;
        n = 0;
        do begin
            advance();
            repeat (hold) cyc();
            n++;
        end while (!(x == tx && y == ty) && n < 200);
    endtask

    task automatic ack_pulse();
        frame_ack = 1'b1;
        step();
        frame_ack = 1'b0;
    endtask

    // ROI column c holds screen x = 2 + c; the frame's pixel offset is added on top.
    task automatic read_chk(input int a, input int o);
        rd_addr = 4'(a);
        step();
        chk($sformatf("rd_a%0d_o%0d", a, o), {23'd0, rd_data}, 32'(9'(2 + (a % 4) + o)));
    endtask

    initial begin
        reset     = 1'b0;
        frame_ack = 1'b0;
        rd_addr   = '0;
        ofs       = 0;
        x         = 9;
        y         = 5;
        drive();

        #12;
        chk("rst_frame_rdy", 32'(frame_rdy), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_busy", 32'(capture_busy), 32'd0);
        chk("rst_clip_busy", 32'(c_capture_busy), 32'd0);
`ifdef ROI_DROP_COUNT_EN
        chk("rst_dropped", 32'(dropped_frames), 32'd0);
`endif
        cyc();
        reset = 1'b1;
        cyc();

        // Basic capture
        run_to(0, 0, 1);
        chk("t1_busy_origin", 32'(capture_busy), 32'd1);
        chk("t1_clip_busy_origin", 32'(c_capture_busy), 32'd1);
        run_to(5, 3, 1);
        chk("t1_rdy_at_last", 32'(frame_rdy), 32'd0);
        chk("t1_busy_commit", 32'(capture_busy), 32'd0);
        step();
        chk("t1_rdy_after_commit", 32'(frame_rdy), 32'd1);
        chk("t1_busy_idle", 32'(capture_busy), 32'd0);
        for (int a = 0; a < 12; a++) read_chk(a, 0);
        chk("t1_clip_rdy", 32'(c_frame_rdy), 32'd0);

        // No ack: second frame dropped, read bank untouched
        ofs = 16;
        run_to(5, 3, 1);
        step();
        chk("t2_rdy_held", 32'(frame_rdy), 32'd1);
`ifdef ROI_DROP_COUNT_EN
        chk("t2_dropped", 32'(dropped_frames), 32'd1);
`endif
        read_chk(0, 0);
        read_chk(5, 0);
        read_chk(11, 0);
        rd_addr = 4'd13;
        step();
        read_chk(0, 0);
        ack_pulse();
        chk("t2_rdy_cleared", 32'(frame_rdy), 32'd0);
        ofs = 32;
        run_to(5, 3, 1);
        chk("t2_rdy_before_commit", 32'(frame_rdy), 32'd0);
        step();
        chk("t2_rdy_new_frame", 32'(frame_rdy), 32'd1);
        read_chk(0, 32);
        read_chk(6, 32);
        read_chk(11, 32);

        // Ack coinciding with COMMIT
        ofs = 48;
        run_to(5, 3, 1);
        ack_pulse();
        chk("t3_rdy_stays", 32'(frame_rdy), 32'd1);
`ifdef ROI_DROP_COUNT_EN
        chk("t3_dropped", 32'(dropped_frames), 32'd1);
`endif
        read_chk(0, 48);
        read_chk(7, 48);
        read_chk(11, 48);

        // Slow stream: each coordinate held 3 clocks
        ack_pulse();
        chk("t4_rdy_cleared", 32'(frame_rdy), 32'd0);
        ofs = 64;
        run_to(5, 3, 3);
        chk("t4_rdy", 32'(frame_rdy), 32'd1);
        for (int a = 0; a < 12; a++) read_chk(a, 64);

        // Reset mid-capture at (3,2)
        ofs = 0;
        run_to(3, 2, 1);
        chk("t5_busy_before", 32'(capture_busy), 32'd1);
        chk("t5_rdy_before", 32'(frame_rdy), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_async_rdy", 32'(frame_rdy), 32'd0);
        chk("t5_async_busy", 32'(capture_busy), 32'd0);
        chk("t5_async_rd_data", 32'(rd_data), 32'd0);
        chk("t5_async_clip_busy", 32'(c_capture_busy), 32'd0);
        cyc();
        reset = 1'b1;
`ifdef ROI_DROP_COUNT_EN
        chk("t5_dropped_reset", 32'(dropped_frames), 32'd0);
`endif
        ack_pulse();
        chk("t5_ack_ignored", 32'(frame_rdy), 32'd0);
        run_to(9, 5, 1);
        chk("t5_idle_to_eof", 32'(capture_busy), 32'd0);
        chk("t5_rdy_eof", 32'(frame_rdy), 32'd0);
        ofs = 96;
        run_to(0, 0, 1);
        chk("t5_busy_restart", 32'(capture_busy), 32'd1);
        run_to(5, 3, 1);
        chk("t5_rdy_at_last", 32'(frame_rdy), 32'd0);
        step();
        chk("t5_rdy", 32'(frame_rdy), 32'd1);
        read_chk(0, 96);
        read_chk(3, 96);
        read_chk(8, 96);
        read_chk(11, 96);

        // Clipped ROI never completes
        run_to(9, 5, 1);
        run_to(9, 5, 1);
        chk("t6_clip_rdy", 32'(c_frame_rdy), 32'd0);
        chk("t6_clip_busy", 32'(c_capture_busy), 32'd1);
`ifdef ROI_DROP_COUNT_EN
        chk("t6_clip_dropped", 32'(c_dropped_frames), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
